// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions for the panel display blocks.
// Segment patterns are active-high, bit order {a,b,c,d,e,f,g} with a in bit 6.
package seg7_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_DASH  = 7'b0000001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Converts an active-high pattern to the physical pin level.
    function automatic seg_t seg_to_pins(input seg_t pattern, input bit act_low);
        return act_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD to active-high 7-segment decoder.
// Codes 10..15 are not decimal digits and show a dash.
module seg7_scan_driver_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       pattern
);

    always_comb begin
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered BCD, leading-zero
// suppression, per-digit blink and configurable pin polarity.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam seg_t              SEG_OFF = seg_to_pins(SEG_BLANK, SEG_ACT_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   display;
    logic                  pending;

    logic                  tick;
    logic                  boundary;
    logic [IW-1:0]         idx_next;
    logic [4*DIGITS-1:0]   display_next;
    logic                  phase_next;
    logic [DIGITS-1:0]     upper_zero;
    logic [3:0]            digit_code;
    seg_t                  digit_pattern;
    logic                  digit_blank;
    seg_t                  seg_next;
    logic [DIGITS-1:0]     an_next;

    assign tick     = (presc == PRESC_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_comb begin
        idx_next = idx;
        if (tick) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // A load landing on the boundary edge bypasses the shadow so it is not a frame late.
    always_comb begin
        display_next = display;
        if (boundary) begin
            if (load) begin
                display_next = bcd_in;
            end else if (pending) begin
                display_next = shadow;
            end
        end
    end

    assign phase_next = blink_phase ^ (boundary && (frame_cnt == FRAME_LAST));

    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (display_next[4*i +: 4] == 4'd0);
            upper_zero[i] = all_zero;
        end
    end

    assign digit_code = display_next[4*int'(idx_next) +: 4];

    seg7_scan_driver_decode u_decode (
        .bcd     (digit_code),
        .pattern (digit_pattern)
    );

    // Rendering uses post-edge state so a committed frame shows from its first digit.
    always_comb begin
        digit_blank = (lz_en && (idx_next != '0) && upper_zero[idx_next])
                   || (phase_next && blink_mask[idx_next]);
        seg_next    = seg_to_pins(digit_blank ? SEG_BLANK : digit_pattern, SEG_ACT_LOW != 0);
        an_next     = DIGITS'(1) << idx_next;
        if (AN_ACT_LOW != 0) begin
            an_next = ~an_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= IDX_LAST;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            idx   <= idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            display <= display_next;
            if (load) begin
                shadow <= bcd_in;
            end
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_phase <= phase_next;
            if (boundary) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (tick) begin
                seg <= seg_next;
                an  <= an_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver with a behavioural display model.
module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int REFRESH_DIV  = 4;
    localparam int BLINK_FRAMES = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    expect_t     exp_q[$];
    int          checks = 0;
    int          passes = 0;

    int          m_cycles = 0;
    int          m_ticks = 0;
    int          m_frames = 0;
    logic [15:0] m_display = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 0;
    bit          m_prev_reset = 0;
    logic        m_exp_fs = 1'b0;
    bit          m_tick;
    bit          m_boundary;
    int          m_pos;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .bcd_in      (bcd_in),
        .lz_en       (lz_en),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lit segments for each decimal value, {a..g} active-high.
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] table_q [10];
        table_q = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        return (v < 10) ? table_q[v] : 7'h01;
    endfunction

    function automatic expect_t render(input int pos);
        expect_t e;
        int      value;
        bit      blank;
        value = int'(m_display);
        blank = (lz_en && pos != 0 && (value >> (4*pos)) == 0)
             || (((m_frames / BLINK_FRAMES) % 2 == 1) && blink_mask[pos]);
        e.seg = ~(blank ? 7'h00 : glyph((value >> (4*pos)) & 15));
        e.an  = ~(4'(1 << pos));
        return e;
    endfunction

    // Reference model: scan position and frame number follow from counted cycles.
    always @(posedge clk) begin
        if (reset) begin
            if (!m_prev_reset) exp_q.push_back('{seg: 7'h7F, an: 4'hF});
            m_cycles = 0; m_ticks = 0; m_frames = 0;
            m_display = '0; m_shadow = '0; m_pending = 0; m_exp_fs = 1'b0;
        end else begin
            m_cycles++;
            m_tick = (m_cycles % REFRESH_DIV == 0);
            m_pos = m_ticks % DIGITS;
            m_boundary = m_tick && m_pos == 0;
            if (m_tick) m_ticks++;
            if (m_boundary) begin
                if (load) m_display = bcd_in;
                else if (m_pending) m_display = m_shadow;
                m_pending = 0;
                m_frames++;
            end else if (load) begin
                m_pending = 1;
            end
            if (load) m_shadow = bcd_in;
            if (m_tick) exp_q.push_back(render(m_pos));
            m_exp_fs = m_boundary;
        end
        m_prev_reset = reset;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual === required) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    endtask

    // Monitor: every visible change of seg/an must match the next scoreboard entry.
    initial begin
        logic [6:0] last_seg;
        logic [3:0] last_an;
        expect_t    e;
        last_seg = 'x;
        last_an  = 'x;
        forever begin
            @(negedge clk);
            checkOutput("frame_start", 16'(frame_start), 16'(m_exp_fs));
            if (seg !== last_seg || an !== last_an) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_update seg=%b an=%b required no change at %0t", seg, an, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("seg", 16'(seg), 16'(e.seg));
                    checkOutput("an", 16'(an), 16'(e.an));
                end
                last_seg = seg;
                last_an  = an;
            end
        end
    end

    task automatic applyStimulus(input bit ld, input logic [15:0] bcd, input bit lz, input logic [3:0] mask);
        @(negedge clk);
        load = ld; bcd_in = bcd; lz_en = lz; blink_mask = mask;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Positions inputs so the next posedge is a frame boundary tick.
    task automatic waitBoundaryEdge();
        for (int n = 0; n < 100; n++) begin
            if (((m_cycles + 1) % REFRESH_DIV == 0) && (m_ticks % DIGITS == 0)) return;
            @(negedge clk);
        end
        checks++;
        $display("[TB] FAIL boundary_wait actual=timeout required=boundary");
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; bcd_in = '0; lz_en = 1'b0; blink_mask = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        runCycles(6);

        applyStimulus(1, 16'h1234, 0, 4'b0000);
        runCycles(36);
        applyStimulus(1, 16'h0007, 1, 4'b0000);
        runCycles(36);
        applyStimulus(1, 16'h00A0, 1, 4'b0000);
        runCycles(36);

        applyStimulus(1, 16'h1111, 1, 4'b0000);
        applyStimulus(1, 16'h2222, 1, 4'b0000);
        waitBoundaryEdge();
        load = 1'b1; bcd_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        runCycles(20);

        applyStimulus(1, 16'h8888, 0, 4'b0001);
        runCycles(90);
        runCycles(7);
        reset = 1'b1;
        runCycles(2);
        reset = 1'b0;
        runCycles(40);

        for (int k = 0; k < 40; k++) begin
            runCycles($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) begin
                waitBoundaryEdge();
                load = 1'b1; bcd_in = 16'($urandom); lz_en = 1'($urandom); blink_mask = 4'($urandom);
                @(negedge clk);
                load = 1'b0;
            end else begin
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
            end
            if ($urandom_range(0, 14) == 0) begin
                runCycles(20);
                reset = 1'b1;
                runCycles($urandom_range(1, 3));
                reset = 1'b0;
            end
        end
        runCycles(40);

        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
